l2_cfg_master: RTL and testbench
================================

L2_CFG_MASTER -- requirements
Module: l2_cfg_master

Interface
REQ-001 SHALL have parameter TL_RS, default 3, meaning the TileLink source-ID width.
REQ-002 SHALL have parameter SOURCE_ID, default 0, meaning the fixed source ID driven on the A channel.
REQ-003 SHALL have parameter TIMEOUT, default 255, meaning the D-channel wait limit in cycles (range 1..65535).
REQ-004 SHALL have one clock and a synchronous, active-high reset, with the ports listed below.
- l2_clock_i  in  1  clock
- l2_reset_i  in  1  synchronous active-high reset
REQ-005 SHALL have a command interface:
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1=write, 0=read
- cmd_address  in  4  byte address
- cmd_mask  in  4  write byte enables
- cmd_data  in  32  write data
REQ-006 SHALL have a response interface:
- rsp_valid  out  1  one-cycle response pulse
- rsp_data  out  32  read data
- rsp_error  out  1  denied/corrupt/protocol/misaligned/timeout
- rsp_timeout  out  1  error cause was timeout
REQ-007 SHALL have TL-UL A-channel outputs:
- l2_a_opcode  out  3
- l2_a_param  out  3
- l2_a_size  out  4
- l2_a_source  out  TL_RS
- l2_a_address  out  4
- l2_a_mask  out  4
- l2_a_data  out  32
- l2_a_corrupt  out  1
- l2_a_valid  out  1
- l2_a_ready  in  1
REQ-008 SHALL have TL-UL D-channel inputs, plus one output:
- l2_d_opcode  in  3
- l2_d_param  in  2
- l2_d_size  in  4
- l2_d_source  in  TL_RS
- l2_d_denied  in  1
- l2_d_data  in  32
- l2_d_corrupt  in  1
- l2_d_valid  in  1
- l2_d_ready  out  1

Function
REQ-009 SHALL implement the FSM states IDLE, A_SEND, D_WAIT and DRAIN.
REQ-010 SHALL assert cmd_ready only in IDLE; a command is accepted on the cycle where cmd_valid and cmd_ready are both high.
REQ-011 SHALL reject a command with cmd_address[1:0]!=0 without any bus transaction: rsp_valid=1 and rsp_error=1 on the next cycle, and the FSM stays in IDLE.
REQ-012 SHALL, on acceptance of an aligned command, register the command into the A fields and move to A_SEND on the next cycle.
REQ-013 SHALL drive the A-channel fields as follows:
- opcode: 4 (Get) for a read; 0 (PutFullData) for a write with mask=4'hF; 1 (PutPartialData) otherwise
- param=0, size=2, source=SOURCE_ID, corrupt=0
- mask=4'hF for a read
- data=0 for a read
REQ-014 SHALL hold l2_a_valid high in A_SEND, with all A fields stable, until l2_a_ready is high; on that handshake it SHALL go to D_WAIT and clear the timeout counter.
REQ-015 SHALL assert l2_d_ready only in D_WAIT and DRAIN, and SHALL ignore D beats in other states.
REQ-016 SHALL, in D_WAIT, accept a D handshake and pulse rsp_valid on the next cycle, then return to IDLE.
- rsp_data = l2_d_data for AccessAckData (1), else 0
- rsp_error = d_denied, or d_corrupt, or d_source!=SOURCE_ID, or opcode mismatch (a read expects 1, a write expects 0)
REQ-017 SHALL increment a 16-bit counter in D_WAIT on every cycle without a D handshake.
REQ-018 SHALL, when the counter reaches TIMEOUT in D_WAIT, pulse rsp_valid with rsp_error=1, rsp_timeout=1 and rsp_data=0, then enter DRAIN.
REQ-019 SHALL, in DRAIN, discard exactly one D beat without a response and then return to IDLE; cmd_ready SHALL stay low throughout DRAIN.
REQ-020 SHALL give priority to the D handshake when it coincides with the cycle the timeout is reached: a normal response is produced and no timeout is reported.
REQ-021 SHALL never change the A fields while l2_a_valid=1 and l2_a_ready=0.
REQ-022 SHALL keep rsp_valid, rsp_error and rsp_timeout low except during a one-cycle pulse.

Reset
REQ-023 SHALL, on l2_reset_i high at a clock edge, enter IDLE from any state, including mid-transaction.
- l2_a_valid=0, l2_d_ready=0, rsp_valid=0, rsp_error=0, rsp_timeout=0, rsp_data=0
- counter=0; A fields=0
- cmd_ready=1 in the first cycle after reset deasserts

Verification
REQ-024 SHALL be verified with read addr 4, a_ready stalled 3 cycles, then D AccessAckData data 32'h07090401 -> opcode 4 held stable; rsp_valid pulse with rsp_data=32'h07090401 and rsp_error=0.
REQ-025 SHALL be verified with write addr 8, mask F, data 32'h1234, then D AccessAck -> opcode 0; rsp_error=0.
REQ-026 SHALL be verified with write mask 4'h3 -> opcode 1 and mask 3; a D reply with denied=1 gives rsp_error=1.
REQ-027 SHALL be verified with read addr 2 -> no l2_a_valid; rsp_error=1 on the next cycle.
REQ-028 SHALL be verified with TIMEOUT=4 and no D reply -> rsp_error=1 and rsp_timeout=1 after 4 wait cycles; a late D beat is swallowed with no rsp_valid; cmd_ready returns afterwards.
REQ-029 SHALL be verified with reset asserted in D_WAIT -> all outputs take their reset values and cmd_ready=1 in the next cycle.

Source files
------------

// File: rtl/l2_cfg_master_if.sv
// l2_cfg_master_if: command, response and TL-UL A/D channel bundle for l2_cfg_master
interface l2_cfg_master_if #(
  parameter int TL_RS = 3
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [3:0]        cmd_address;
  logic [3:0]        cmd_mask;
  logic [31:0]       cmd_data;
  logic              rsp_valid;
  logic [31:0]       rsp_data;
  logic              rsp_error;
  logic              rsp_timeout;
  logic [2:0]        l2_a_opcode;
  logic [2:0]        l2_a_param;
  logic [3:0]        l2_a_size;
  logic [TL_RS-1:0]  l2_a_source;
  logic [3:0]        l2_a_address;
  logic [3:0]        l2_a_mask;
  logic [31:0]       l2_a_data;
  logic              l2_a_corrupt;
  logic              l2_a_valid;
  logic              l2_a_ready;
  logic [2:0]        l2_d_opcode;
  logic [1:0]        l2_d_param;
  logic [3:0]        l2_d_size;
  logic [TL_RS-1:0]  l2_d_source;
  logic              l2_d_denied;
  logic [31:0]       l2_d_data;
  logic              l2_d_corrupt;
  logic              l2_d_valid;
  logic              l2_d_ready;
  modport master (
    input  cmd_valid, cmd_write, cmd_address, cmd_mask, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, rsp_error, rsp_timeout,
    output l2_a_opcode, l2_a_param, l2_a_size, l2_a_source, l2_a_address,
    output l2_a_mask, l2_a_data, l2_a_corrupt, l2_a_valid,
    input  l2_a_ready,
    input  l2_d_opcode, l2_d_param, l2_d_size, l2_d_source, l2_d_denied,
    input  l2_d_data, l2_d_corrupt, l2_d_valid,
    output l2_d_ready
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_address, cmd_mask, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, rsp_error, rsp_timeout,
    input  l2_a_opcode, l2_a_param, l2_a_size, l2_a_source, l2_a_address,
    input  l2_a_mask, l2_a_data, l2_a_corrupt, l2_a_valid,
    output l2_a_ready,
    output l2_d_opcode, l2_d_param, l2_d_size, l2_d_source, l2_d_denied,
    output l2_d_data, l2_d_corrupt, l2_d_valid,
    input  l2_d_ready
  );
endinterface

// File: rtl/l2_cfg_master.sv
// l2_cfg_master: single-outstanding TL-UL master turning 32-bit config commands into Get/Put transactions
module l2_cfg_master #(
  parameter int TL_RS     = 3,
  parameter int SOURCE_ID = 0,
  parameter int TIMEOUT   = 255
) (
  input logic              l2_clock_i,
  input logic              l2_reset_i,
  l2_cfg_master_if.master  bus
);
  typedef enum logic [1:0] {IDLE, A_SEND, D_WAIT, DRAIN} state_t;
  localparam logic [TL_RS-1:0] SRC = TL_RS'(SOURCE_ID);
  state_t      state;
  logic [15:0] cnt;
  logic        d_err;
  logic        unused_d;
  assign bus.cmd_ready    = state == IDLE;
  assign bus.l2_a_valid   = state == A_SEND;
  assign bus.l2_d_ready   = state == D_WAIT || state == DRAIN;
  assign bus.l2_a_param   = 3'd0;
  assign bus.l2_a_corrupt = 1'b0;
  assign unused_d         = ^{bus.l2_d_param, bus.l2_d_size};
  // a Get must be answered by AccessAckData (1), a Put by AccessAck (0)
  assign d_err = bus.l2_d_denied | bus.l2_d_corrupt | (bus.l2_d_source != SRC) |
                 (bus.l2_d_opcode != (bus.l2_a_opcode == 3'd4 ? 3'd1 : 3'd0));
  // transaction FSM; A fields only load in IDLE so they stay frozen while a_valid is high
  always_ff @(posedge l2_clock_i) begin
    if (l2_reset_i) begin
      state            <= IDLE;
      cnt              <= '0;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_error    <= 1'b0;
      bus.rsp_timeout  <= 1'b0;
      bus.rsp_data     <= '0;
      bus.l2_a_opcode  <= '0;
      bus.l2_a_size    <= '0;
      bus.l2_a_source  <= '0;
      bus.l2_a_address <= '0;
      bus.l2_a_mask    <= '0;
      bus.l2_a_data    <= '0;
    end else begin
      bus.rsp_valid   <= 1'b0;
      bus.rsp_error   <= 1'b0;
      bus.rsp_timeout <= 1'b0;
      bus.rsp_data    <= '0;
      case (state)
        IDLE: if (bus.cmd_valid) begin
          if (bus.cmd_address[1:0] != 2'b00) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_error <= 1'b1;
          end else begin
            bus.l2_a_opcode  <= !bus.cmd_write ? 3'd4 : (bus.cmd_mask == 4'hF ? 3'd0 : 3'd1);
            bus.l2_a_size    <= 4'd2;
            bus.l2_a_source  <= SRC;
            bus.l2_a_address <= bus.cmd_address;
            bus.l2_a_mask    <= bus.cmd_write ? bus.cmd_mask : 4'hF;
            bus.l2_a_data    <= bus.cmd_write ? bus.cmd_data : 32'd0;
            state            <= A_SEND;
          end
        end
        A_SEND: if (bus.l2_a_ready) begin
          cnt   <= '0;
          state <= D_WAIT;
        end
        D_WAIT: if (bus.l2_d_valid) begin
          bus.rsp_valid <= 1'b1;
          bus.rsp_data  <= bus.l2_d_opcode == 3'd1 ? bus.l2_d_data : 32'd0;
          bus.rsp_error <= d_err;
          state         <= IDLE;
        end else if (cnt == 16'(TIMEOUT)) begin
          bus.rsp_valid   <= 1'b1;
          bus.rsp_error   <= 1'b1;
          bus.rsp_timeout <= 1'b1;
          state           <= DRAIN;
        end else begin
          cnt <= cnt + 16'd1;
        end
        DRAIN: if (bus.l2_d_valid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_l2_cfg_master.sv
// tb_l2_cfg_master: randomized scoreboard bench for l2_cfg_master against a transaction-level model
module tb_l2_cfg_master;
  localparam int TO = 4;
  typedef struct packed {logic [31:0] data; logic err; logic to;} rsp_t;
  typedef struct packed {
    logic [2:0] op; logic [2:0] par; logic [3:0] size; logic [2:0] src;
    logic [3:0] addr; logic [3:0] mask; logic [31:0] data; logic cor;
  } a_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;
  rsp_t exp_q[$];
  rsp_t mon_e;
  rsp_t mon_act;
  a_t   exp_a;
  a_t   act_a;
  bit   a_expect = 1'b0;
  bit          r_w, r_den, r_cor;
  logic [3:0]  r_addr, r_mask;
  logic [31:0] r_data, r_ddata;
  logic [2:0]  r_dop, r_dsrc;
  int          r_stall, r_dly;
  l2_cfg_master_if #(.TL_RS(3)) bus ();
  l2_cfg_master #(.TL_RS(3), .SOURCE_ID(2), .TIMEOUT(TO)) dut (
    .l2_clock_i(clk),
    .l2_reset_i(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always_comb act_a = {bus.l2_a_opcode, bus.l2_a_param, bus.l2_a_size, bus.l2_a_source,
                       bus.l2_a_address, bus.l2_a_mask, bus.l2_a_data, bus.l2_a_corrupt};
  // monitor: pops the scoreboard on every response pulse and checks the A channel while valid
  always @(negedge clk) begin
    if (!rst) begin
      mon_act = {bus.rsp_data, bus.rsp_error, bus.rsp_timeout};
      n_tests++;
      if (bus.rsp_valid) begin
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_rsp: got %h with no response expected", mon_act);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_act !== mon_e) begin
            n_fail++;
            $display("FAIL rsp: got data/err/to %h expected %h", mon_act, mon_e);
          end
        end
      end else if (bus.rsp_error !== 1'b0 || bus.rsp_timeout !== 1'b0) begin
        n_fail++;
        $display("FAIL rsp_quiet: got err=%b to=%b expected 0 0", bus.rsp_error, bus.rsp_timeout);
      end
      if (bus.l2_a_valid) begin
        n_tests++;
        if (!a_expect || act_a !== exp_a) begin
          n_fail++;
          $display("FAIL a_channel: got %h expected %h (a_expect=%b)", act_a, exp_a, a_expect);
        end
      end
    end
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic wait_cmd_ready();
    int k = 0;
    while (bus.cmd_ready !== 1'b1 && k < 50) begin
      @(posedge clk); #1; k++;
    end
    chk("cmd_ready_wait", 64'(bus.cmd_ready), 64'd1);
  endtask
  task automatic txn(input bit w, input logic [3:0] addr, input logic [3:0] mask, input logic [31:0] data,
                     input int stall, input int dly, input logic [2:0] dop, input bit den, input bit cor,
                     input logic [2:0] dsrc, input logic [31:0] ddata);
    bit aligned;
    int k;
    aligned = addr[1:0] == 2'b00;
    wait_cmd_ready();
    if (!aligned) exp_q.push_back('{data: 32'd0, err: 1'b1, to: 1'b0});
    else if (dly > TO) exp_q.push_back('{data: 32'd0, err: 1'b1, to: 1'b1});
    else exp_q.push_back('{data: dop == 3'd1 ? ddata : 32'd0,
                           err: den | cor | (dsrc != 3'd2) | (dop != (w ? 3'd0 : 3'd1)), to: 1'b0});
    exp_a = {w ? (mask == 4'hF ? 3'd0 : 3'd1) : 3'd4, 3'd0, 4'd2, 3'd2, addr,
             w ? mask : 4'hF, w ? data : 32'd0, 1'b0};
    a_expect = aligned;
    bus.cmd_valid = 1'b1; bus.cmd_write = w; bus.cmd_address = addr;
    bus.cmd_mask = mask; bus.cmd_data = data;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    if (!aligned) return;
    repeat (stall) begin @(posedge clk); #1; end
    bus.l2_a_ready = 1'b1;
    k = 0;
    while (bus.l2_a_valid !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
    chk("a_valid_wait", 64'(bus.l2_a_valid), 64'd1);
    @(posedge clk); #1;
    bus.l2_a_ready = 1'b0;
    a_expect = 1'b0;
    repeat (dly) begin @(posedge clk); #1; end
    if (dly > TO) chk("drain_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    bus.l2_d_valid = 1'b1; bus.l2_d_opcode = dop; bus.l2_d_denied = den; bus.l2_d_corrupt = cor;
    bus.l2_d_source = dsrc; bus.l2_d_data = ddata;
    k = 0;
    while (bus.l2_d_ready !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
    chk("d_ready_wait", 64'(bus.l2_d_ready), 64'd1);
    @(posedge clk); #1;
    bus.l2_d_valid = 1'b0;
    if (dly > TO) chk("post_drain_cmd_ready", 64'(bus.cmd_ready), 64'd1);
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_a_valid"}, 64'(bus.l2_a_valid), 64'd0);
    chk({tag, "_d_ready"}, 64'(bus.l2_d_ready), 64'd0);
    chk({tag, "_rsp"}, 64'({bus.rsp_valid, bus.rsp_error, bus.rsp_timeout, bus.rsp_data}), 64'd0);
    chk({tag, "_a_fields"}, 64'(act_a), 64'd0);
  endtask
  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_address = '0; bus.cmd_mask = '0; bus.cmd_data = '0;
    bus.l2_a_ready = 1'b0;
    bus.l2_d_valid = 1'b0; bus.l2_d_opcode = '0; bus.l2_d_param = '0; bus.l2_d_size = 4'd2;
    bus.l2_d_source = '0; bus.l2_d_denied = 1'b0; bus.l2_d_data = '0; bus.l2_d_corrupt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    txn(1'b0, 4'd4, 4'h0, 32'd0, 3, 1, 3'd1, 1'b0, 1'b0, 3'd2, 32'h07090401);
    txn(1'b1, 4'd8, 4'hF, 32'h1234, 0, 0, 3'd0, 1'b0, 1'b0, 3'd2, 32'hDEAD);
    txn(1'b1, 4'hC, 4'h3, 32'hA5A5_5A5A, 1, 2, 3'd0, 1'b1, 1'b0, 3'd2, 32'd0);
    txn(1'b0, 4'd2, 4'h0, 32'd0, 0, 0, 3'd1, 1'b0, 1'b0, 3'd2, 32'd0);
    txn(1'b0, 4'd0, 4'h0, 32'd0, 0, TO + 1, 3'd1, 1'b0, 1'b0, 3'd2, 32'h5555);
    txn(1'b0, 4'd4, 4'h0, 32'd0, 2, TO, 3'd1, 1'b0, 1'b0, 3'd2, 32'h0BAD_F00D);
    txn(1'b0, 4'd8, 4'h0, 32'd0, 0, 0, 3'd0, 1'b0, 1'b0, 3'd2, 32'h1111);
    txn(1'b1, 4'd0, 4'hF, 32'h77, 0, 0, 3'd0, 1'b0, 1'b0, 3'd5, 32'd0);
    wait_cmd_ready();
    exp_a = {3'd4, 3'd0, 4'd2, 3'd2, 4'd0, 4'hF, 32'd0, 1'b0};
    a_expect = 1'b1;
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_address = 4'd0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0; bus.l2_a_ready = 1'b1;
    @(posedge clk); #1;
    bus.l2_a_ready = 1'b0; a_expect = 1'b0;
    @(posedge clk); #1;
    chk("dwait_d_ready", 64'(bus.l2_d_ready), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_outputs("midrst");
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    for (int i = 0; i < 60; i++) begin
      r_w = 1'($urandom_range(0, 1));
      r_addr = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) r_addr[1:0] = 2'b00;
      r_mask = 4'($urandom);
      r_data = $urandom;
      r_stall = $urandom_range(0, 3);
      r_dly = $urandom_range(0, TO + 2);
      r_dop = $urandom_range(0, 7) == 0 ? 3'($urandom) : (r_w ? 3'd0 : 3'd1);
      r_den = $urandom_range(0, 7) == 0;
      r_cor = $urandom_range(0, 7) == 0;
      r_dsrc = $urandom_range(0, 7) == 0 ? 3'($urandom) : 3'd2;
      r_ddata = $urandom;
      txn(r_w, r_addr, r_mask, r_data, r_stall, r_dly, r_dop, r_den, r_cor, r_dsrc, r_ddata);
    end
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
